// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle main controller:
// state enum, ALU codes, mux encodings, condition codes and the ALU command decoder.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, BLLINK
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_ORR = 4'b0011;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // wb: result may be written back; cv: op produces meaningful carry/overflow
  typedef struct packed {
    logic [3:0] ctrl;
    logic       wb;
    logic       cv;
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
    alu_dec_t d;
    d = '{ctrl: ALU_ADD, wb: 1'b0, cv: 1'b0};
    case (cmd)
      4'b0100: d = '{ctrl: ALU_ADD, wb: 1'b1, cv: 1'b1};
      4'b0010: d = '{ctrl: ALU_SUB, wb: 1'b1, cv: 1'b1};
      4'b1010: d = '{ctrl: ALU_SUB, wb: 1'b0, cv: 1'b1};
      4'b0000: d = '{ctrl: ALU_AND, wb: 1'b1, cv: 1'b0};
      4'b1100: d = '{ctrl: ALU_ORR, wb: 1'b1, cv: 1'b0};
      default: d = '{ctrl: ALU_ADD, wb: 1'b0, cv: 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// Condition evaluation: {N,Z,C,V} flags register, combinational CondEx and
// the CondExR latch captured when leaving DECODE.
module mc_cond_unit
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       decode,
  input  logic       flag_we,
  input  logic       cv_we,
  output logic       condex,
  output logic       condexr,
  output logic [3:0] flags
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    condex = 1'b0;
    case (cond)
      COND_EQ: condex = z;
      COND_NE: condex = ~z;
      COND_CS: condex = c;
      COND_CC: condex = ~c;
      COND_MI: condex = n;
      COND_PL: condex = ~n;
      COND_VS: condex = v;
      COND_VC: condex = ~v;
      COND_HI: condex = c & ~z;
      COND_LS: condex = ~c | z;
      COND_GE: condex = (n == v);
      COND_LT: condex = (n != v);
      COND_GT: condex = ~z & (n == v);
      COND_LE: condex = z | (n != v);
      COND_AL: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      condexr <= 1'b0;
      flags   <= 4'b0000;
    end else begin
      if (decode)
        condexr <= condex;
      // Gated by the latched condition, so an instruction only ever sees older flags
      if (flag_we && condexr) begin
        flags[3:2] <= alu_flags[3:2];
        if (cv_we)
          flags[1:0] <= alu_flags[1:0];
      end
    end
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Multicycle main controller FSM. Define MC_BL_EN to add the BLLINK state
// (branch-with-link writes R14); otherwise BL behaves as a plain branch.
module mc_main_fsm
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] ALUControl,
  output logic       BL
);

  state_t   state, next;
  alu_dec_t dec;
  logic     condex, condexr;
  logic [3:0] flags;
  logic     irwrite_n, pcwrite_n, regwrite_n, memwrite_n, bl_n;
  logic     unused_rd;

  assign unused_rd = ^Rd;
  assign dec = alu_decode(Funct[4:1]);

  mc_cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (Cond),
    .alu_flags (ALUFlags),
    .decode    (state == DECODE),
    .flag_we   ((state == EXECR || state == EXECI) && Funct[0]),
    .cv_we     (dec.cv),
    .condex    (condex),
    .condexr   (condexr),
    .flags     (flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    next       = state;
    irwrite_n  = 1'b0;
    pcwrite_n  = 1'b0;
    regwrite_n = 1'b0;
    memwrite_n = 1'b0;
    bl_n       = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state)
      FETCH: begin
        next      = DECODE;
        irwrite_n = 1'b1;
        pcwrite_n = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (Op)
          2'b00:   next = Funct[5] ? EXECI : EXECR;
          2'b01:   next = MEMADR;
          2'b10:   next = BRANCH;
          default: next = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = Funct[3] ? ALU_ADD : ALU_SUB;
        next       = Funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        next   = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = RES_DATA;
        regwrite_n = condexr;
        next       = FETCH;
      end
      MEMWR: begin
        AdrSrc     = 1'b1;
        memwrite_n = condexr;
        next       = FETCH;
      end
      EXECR: begin
        ALUControl = dec.ctrl;
        next       = ALUWB;
      end
      EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = dec.ctrl;
        next       = ALUWB;
      end
      ALUWB: begin
        regwrite_n = condexr & dec.wb;
        next       = FETCH;
      end
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pcwrite_n = condexr;
`ifdef MC_BL_EN
        next      = (Funct[4] && condexr) ? BLLINK : FETCH;
`else
        next      = FETCH;
`endif
      end
`ifdef MC_BL_EN
      BLLINK: begin
        bl_n       = 1'b1;
        regwrite_n = 1'b1;
        ResultSrc  = RES_ALUOUT;
        next       = FETCH;
      end
`endif
      default: next = FETCH;
    endcase
  end

  // Write strobes are held low for the whole reset pulse
  assign IRWrite  = irwrite_n  & ~reset;
  assign PCWrite  = pcwrite_n  & ~reset;
  assign RegWrite = regwrite_n & ~reset;
  assign MemWrite = memwrite_n & ~reset;
  assign BL       = bl_n       & ~reset;

  assign ImmSrc = Op;
  assign RegSrc = {Op == 2'b01, Op == 2'b10};

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed self-checking bench for mc_main_fsm; follows MC_BL_EN like the RTL.
module tb_mc_main_fsm;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       IRWrite, PCWrite, AdrSrc, RegWrite, MemWrite, ALUSrcA, BL;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0] ALUControl;

  int checks = 0;
  int errors = 0;

  mc_main_fsm dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .IRWrite(IRWrite), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .BL(BL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                       input logic [3:0] fl);
    Cond = c; Op = o; Funct = f; ALUFlags = fl;
    #1;
  endtask

  initial begin
    reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'b0; Rd = 4'h1; ALUFlags = 4'b0;
    @(negedge clk);
    chk("rst_state", dut.state, FETCH);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_alusrcb", ALUSrcB, 2'b10);
    chk("rst_resultsrc", ResultSrc, 2'b10);
    chk("rst_flags", dut.u_cond.flags, 4'b0000);
    chk("rst_bl", BL, 0);
    reset = 1'b0;

    // ADD R1,R2,R3
    instr(4'b1110, 2'b00, 6'b001000, 4'b0000);
    chk("add_fetch_st", dut.state, FETCH);
    chk("add_fetch_ir", IRWrite, 1);
    chk("add_fetch_pc", PCWrite, 1);
    chk("add_fetch_srca", ALUSrcA, 1);
    tick();
    chk("add_dec_st", dut.state, DECODE);
    chk("add_dec_rw", RegWrite, 0);
    chk("add_dec_pc", PCWrite, 0);
    tick();
    chk("add_ex_st", dut.state, EXECR);
    chk("add_ex_aluc", ALUControl, 4'b0000);
    chk("add_ex_srcb", ALUSrcB, 2'b00);
    chk("add_ex_rw", RegWrite, 0);
    tick();
    chk("add_wb_st", dut.state, ALUWB);
    chk("add_wb_rw", RegWrite, 1);
    chk("add_wb_res", ResultSrc, 2'b00);
    tick();
    chk("add_done_st", dut.state, FETCH);

    // LDR
    instr(4'b1110, 2'b01, 6'b011001, 4'b0000);
    chk("ldr_immsrc", ImmSrc, 2'b01);
    chk("ldr_regsrc", RegSrc, 2'b10);
    tick();
    tick();
    chk("ldr_adr_st", dut.state, MEMADR);
    chk("ldr_adr_aluc", ALUControl, 4'b0000);
    chk("ldr_adr_srcb", ALUSrcB, 2'b01);
    tick();
    chk("ldr_rd_st", dut.state, MEMRD);
    chk("ldr_rd_adrsrc", AdrSrc, 1);
    chk("ldr_rd_rw", RegWrite, 0);
    tick();
    chk("ldr_wb_st", dut.state, MEMWB);
    chk("ldr_wb_res", ResultSrc, 2'b01);
    chk("ldr_wb_rw", RegWrite, 1);
    tick();
    chk("ldr_done_st", dut.state, FETCH);

    // SUBS immediate giving zero: Z=1, C=1
    instr(4'b1110, 2'b00, 6'b100101, 4'b0110);
    tick();
    tick();
    chk("subs_ex_st", dut.state, EXECI);
    chk("subs_ex_aluc", ALUControl, 4'b0001);
    chk("subs_ex_flags_pre", dut.u_cond.flags, 4'b0000);
    tick();
    chk("subs_wb_flags", dut.u_cond.flags, 4'b0110);
    chk("subs_wb_rw", RegWrite, 1);
    tick();

    // BEQ taken
    instr(4'b0000, 2'b10, 6'b000000, 4'b0000);
    tick();
    chk("beq_dec_immsrc", ImmSrc, 2'b10);
    chk("beq_dec_regsrc", RegSrc, 2'b01);
    tick();
    chk("beq_br_st", dut.state, BRANCH);
    chk("beq_br_pc", PCWrite, 1);
    tick();
    chk("beq_done_st", dut.state, FETCH);

    // BNE not taken
    instr(4'b0001, 2'b10, 6'b000000, 4'b0000);
    tick();
    tick();
    chk("bne_br_st", dut.state, BRANCH);
    chk("bne_br_pc", PCWrite, 0);
    tick();
    chk("bne_done_st", dut.state, FETCH);

    // CMP: Z=1, C=0
    instr(4'b1110, 2'b00, 6'b010101, 4'b0100);
    tick();
    tick();
    chk("cmp_ex_aluc", ALUControl, 4'b0001);
    tick();
    chk("cmp_wb_st", dut.state, ALUWB);
    chk("cmp_wb_rw", RegWrite, 0);
    chk("cmp_wb_flags", dut.u_cond.flags, 4'b0100);
    tick();

    // STRNE with Z=1: suppressed
    instr(4'b0001, 2'b01, 6'b011000, 4'b0000);
    tick();
    tick();
    tick();
    chk("strne_st", dut.state, MEMWR);
    chk("strne_mw", MemWrite, 0);
    chk("strne_adrsrc", AdrSrc, 1);
    tick();
    chk("strne_done_st", dut.state, FETCH);

    // STR AL, subtract offset
    instr(4'b1110, 2'b01, 6'b010000, 4'b0000);
    tick();
    tick();
    chk("str_adr_aluc", ALUControl, 4'b0001);
    tick();
    chk("str_mw", MemWrite, 1);
    tick();

    // ANDS: only N,Z updated
    instr(4'b1110, 2'b00, 6'b000001, 4'b1011);
    tick();
    tick();
    chk("ands_ex_aluc", ALUControl, 4'b0010);
    tick();
    chk("ands_wb_flags", dut.u_cond.flags, 4'b1000);
    chk("ands_wb_rw", RegWrite, 1);
    tick();

    // SUBSEQ with Z=0: no write, no flag update
    instr(4'b0000, 2'b00, 6'b100101, 4'b0110);
    tick();
    tick();
    tick();
    chk("subseq_wb_rw", RegWrite, 0);
    chk("subseq_wb_flags", dut.u_cond.flags, 4'b1000);
    tick();

    // Unknown data-processing command
    instr(4'b1110, 2'b00, 6'b001100, 4'b0000);
    tick();
    tick();
    chk("unk_ex_aluc", ALUControl, 4'b0000);
    tick();
    chk("unk_wb_rw", RegWrite, 0);
    tick();

    // ORR
    instr(4'b1110, 2'b00, 6'b011000, 4'b0000);
    tick();
    tick();
    chk("orr_ex_aluc", ALUControl, 4'b0011);
    tick();
    chk("orr_wb_rw", RegWrite, 1);
    tick();

    // Op=11 NOP: two cycles
    instr(4'b1110, 2'b11, 6'b000000, 4'b0000);
    tick();
    chk("nop_dec_st", dut.state, DECODE);
    tick();
    chk("nop_done_st", dut.state, FETCH);

    // BL (AL)
    instr(4'b1110, 2'b10, 6'b010000, 4'b0000);
    tick();
    tick();
    chk("bl_br_pc", PCWrite, 1);
    chk("bl_br_bl", BL, 0);
    tick();
`ifdef MC_BL_EN
    chk("bl_link_st", dut.state, BLLINK);
    chk("bl_link_bl", BL, 1);
    chk("bl_link_rw", RegWrite, 1);
    chk("bl_link_res", ResultSrc, 2'b00);
    tick();
`else
    chk("bl_nolink_bl", BL, 0);
    chk("bl_nolink_rw", RegWrite, 0);
`endif
    chk("bl_done_st", dut.state, FETCH);

    // Reset pulsed mid-LDR in MEMRD
    instr(4'b1110, 2'b01, 6'b011001, 4'b0000);
    tick();
    tick();
    tick();
    chk("rld_rd_st", dut.state, MEMRD);
    chk("rld_flags_pre", dut.u_cond.flags, 4'b1000);
    reset = 1'b1;
    #1;
    chk("rld_st", dut.state, FETCH);
    chk("rld_flags", dut.u_cond.flags, 4'b0000);
    chk("rld_condexr", dut.u_cond.condexr, 0);
    chk("rld_rw", RegWrite, 0);
    chk("rld_ir", IRWrite, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rld_rel_st", dut.state, FETCH);
    chk("rld_rel_rw", RegWrite, 0);
    tick();
    chk("rld_dec_st", dut.state, DECODE);
    chk("rld_dec_rw", RegWrite, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_main_fsm.md
MC_MAIN_FSM -- requirements
Module: mc_main_fsm

Interface
REQ-001 SHALL have ports: clk in 1, processor clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset in 1, asynchronous active-high reset.
REQ-003 SHALL have ports: Cond in 4, Instr[31:28]; Op in 2, Instr[27:26]; Funct in 6, Instr[25:20]; Rd in 4, Instr[15:12]; ALUFlags in 4, {N,Z,C,V} from ALU.
REQ-004 SHALL have outputs: IRWrite 1; PCWrite 1; AdrSrc 1 (0=PC, 1=ALUOut); RegWrite 1; MemWrite 1; ALUSrcA 1 (0=Rn, 1=PC).
REQ-005 SHALL have outputs: ALUSrcB 2 (00=reg, 01=imm, 10=const 4); ResultSrc 2 (00=ALUOut, 01=Data, 10=ALUResult); ImmSrc 2; RegSrc 2; ALUControl 4; BL 1.

Function
REQ-006 SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH (plus BLLINK per REQ-021).
REQ-007 SHALL transition: FETCH->DECODE always; DECODE: Op=00 & Funct[5]=0 -> EXECR, Op=00 & Funct[5]=1 -> EXECI, Op=01 -> MEMADR, Op=10 -> BRANCH, Op=11 -> FETCH (NOP).
REQ-008 SHALL transition: MEMADR -> MEMRD if Funct[0]=1 else MEMWR; MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH -> FETCH.
REQ-009 SHALL, in FETCH, assert IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD.
REQ-010 SHALL, in DECODE, drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=ADD (PC+8 read), with no write enables.
REQ-011 SHALL decode ALUControl from Funct[4:1] in EXECR/EXECI: 0100->ADD 0000, 0010/1010->SUB 0001, 0000->AND 0010, 1100->ORR 0011, other->ADD with RegWrite suppressed; MEMADR uses ADD if Funct[3]=1 else SUB.
REQ-012 SHALL compute CondEx combinationally in DECODE from Cond and the flags register (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL; 1111 -> 0) and register it as CondExR at DECODE exit.
REQ-013 SHALL gate RegWrite (MEMWB, ALUWB), MEMWR's MemWrite and BRANCH's PCWrite with CondExR; FETCH PCWrite/IRWrite are ungated.
REQ-014 SHALL suppress RegWrite in ALUWB for CMP (Funct[4:1]=1010).
REQ-015 SHALL update flags register at end of EXECR/EXECI only if CondExR=1 and Funct[0]=1: NZ always; CV only for ADD/SUB/CMP.
REQ-016 SHALL give latencies: data-processing 4 cycles, LDR 5, STR 4, B 3, Op=11 2 cycles.
REQ-017 SHALL drive ImmSrc=Op and RegSrc={Op==01, Op==10} in every state.
REQ-018 SHALL treat flag update and CondExR as computed from pre-update flags: an instruction never sees its own flag write.

Reset
REQ-019 SHALL, on reset assertion at any cycle (including mid-instruction), go immediately to FETCH, clear flags to 0000 and CondExR to 0.
REQ-020 SHALL force IRWrite, PCWrite, RegWrite, MemWrite, BL to 0 while reset is high; other outputs take FETCH values.

Configuration
REQ-021 SHALL, with MC_BL_EN defined, route BRANCH -> BLLINK when Funct[4]=1 and CondExR=1; BLLINK asserts BL=1 and RegWrite=1 (R14 <- PC-4 via ResultSrc=00), then -> FETCH (BL = 4 cycles).
REQ-022 SHALL, without MC_BL_EN, treat BL as B, never enter BLLINK and tie BL=0.

Structure
REQ-023 SHALL place state enum, ALUControl codes, ALUSrcB/ResultSrc encodings and cond codes in shared package mc_pkg.
REQ-024 SHALL isolate flags register, CondEx evaluation and CondExR in sub-module mc_cond_unit.

Verification
REQ-025 ADD R1,R2,R3 (Cond=1110, Op=00, Funct=001000) -> states FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in ALUWB.
REQ-026 LDR (Op=01, Funct=011001) -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; ResultSrc=01, RegWrite=1 in MEMWB.
REQ-027 SUBS giving zero, then BEQ (Cond=0000, Op=10) -> flags Z=1, PCWrite=1 in BRANCH; repeated with BNE -> PCWrite=0 in BRANCH.
REQ-028 CMP (Funct=010101) -> RegWrite=0 in ALUWB, flags updated; STR with Cond=0001 after Z=1 -> MemWrite=0.
REQ-029 Reset pulsed in MEMRD -> next state FETCH, flags=0000, no RegWrite pulse.
REQ-030 With MC_BL_EN, BL (Funct[4]=1, AL) -> BLLINK with BL=1, RegWrite=1; without it -> FETCH after BRANCH, BL=0.
